// File: rtl/seg_scan_if.sv
// seg_scan_if: bundle between the scrolling-text generators and the 7-segment
// scan driver.
//   data        [19:0] four 5-bit char codes {d3,d2,d1,d0}; d3 is the leftmost digit
//   dp_en       [3:0]  decimal point request per digit, active-high
//   seg         [7:0]  {dp,g,f,e,d,c,b,a}, active-low, toward the board pins
//   an          [3:0]  digit anodes, active-low
//   frame_start        1-cycle pulse: a new snapshot was taken and digit 0 is selected
// master: the text side (drives data/dp_en). slave: the scan driver.
interface seg_scan_if;
  logic [19:0] data;
  logic [3:0]  dp_en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  modport master (
    output data, dp_en,
    input  seg, an, frame_start
  );

  modport slave (
    input  data, dp_en,
    output seg, an, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: snapshots the 20-bit text bus once per frame, decodes each
// 5-bit code to a 7-segment glyph and time-multiplexes four common-anode digits,
// with a blanking gap at the start of every digit slot to suppress ghosting.
// Ports:
//   clk    system clock, everything on posedge
//   rst_n  asynchronous active-low reset
//   bus    seg_scan_if.slave: data/dp_en in; seg/an/frame_start out (all registered)
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//   BLANK_CYC  cycles the anodes stay off at slot start (< SCAN_DIV-1); 0 and 1
//              both give a single dark cycle (the tick edge itself)
module seg_scan_driver #(
  parameter int SCAN_DIV  = 24000,
  parameter int BLANK_CYC = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [19:0]      frame_q, frame_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             fs_q, fs_d;
  state_t           state_q, state_d;

  logic             tick;
  logic [4:0]       code_sel;
  logic             dp_sel;

  // Active-high glyph {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:  g = 7'h3F;  5'd1:  g = 7'h06;  5'd2:  g = 7'h5B;  5'd3:  g = 7'h4F;
      5'd4:  g = 7'h66;  5'd5:  g = 7'h6D;  5'd6:  g = 7'h7D;  5'd7:  g = 7'h07;
      5'd8:  g = 7'h7F;  5'd9:  g = 7'h6F;  5'd10: g = 7'h77;  5'd11: g = 7'h7C;
      5'd12: g = 7'h39;  5'd13: g = 7'h5E;  5'd14: g = 7'h79;  5'd15: g = 7'h71;
      5'd16: g = 7'h3D;  5'd17: g = 7'h76;  5'd18: g = 7'h06;  5'd19: g = 7'h1E;
      5'd20: g = 7'h38;  5'd21: g = 7'h54;  5'd22: g = 7'h5C;  5'd23: g = 7'h73;
      5'd24: g = 7'h67;  5'd25: g = 7'h50;  5'd26: g = 7'h6D;  5'd27: g = 7'h78;
      5'd28: g = 7'h3E;  5'd29: g = 7'h6E;  5'd30: g = 7'h40;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  function automatic logic [4:0] pick_code(input logic [19:0] frame, input logic [1:0] idx);
    logic [4:0] c;
    case (idx)
      2'd0:    c = frame[4:0];
      2'd1:    c = frame[9:5];
      2'd2:    c = frame[14:10];
      default: c = frame[19:15];
    endcase
    return c;
  endfunction

  assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    blank_cnt_d = blank_cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    dp_d        = dp_q;
    an_d        = an_q;
    seg_d       = seg_q;
    fs_d        = 1'b0;
    state_d     = state_q;
    code_sel    = 5'd31;
    dp_sel      = 1'b0;

    if (tick) begin
      idx_d       = idx_q + 2'd1;
      an_d        = 4'hF;
      state_d     = ST_BLANK;
      blank_cnt_d = CNT_W'(BLANK_CYC);
      if (idx_q == 2'd3) begin
        // Frame wrap: take the snapshot, and decode digit 0 straight from the
        // bus so the new frame is visible in its very first slot.
        frame_d  = bus.data;
        dp_d     = bus.dp_en;
        fs_d     = 1'b1;
        code_sel = bus.data[4:0];
        dp_sel   = bus.dp_en[0];
      end else begin
        code_sel = pick_code(frame_q, idx_d);
        dp_sel   = dp_q[idx_d];
      end
      seg_d = {~dp_sel, ~decode(code_sel)};
    end else begin
      case (state_q)
        ST_BLANK: begin
          // A count of 0 or 1 both release on this edge, so the dark gap is
          // never shorter than the tick cycle itself.
          if (blank_cnt_q <= CNT_W'(1)) begin
            an_d    = ~(4'b0001 << idx_q);
            state_d = ST_DRIVE;
          end else begin
            blank_cnt_d = blank_cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      blank_cnt_q <= '0;
      idx_q       <= 2'd3;
      frame_q     <= {4{5'd31}};
      dp_q        <= 4'h0;
      an_q        <= 4'hF;
      seg_q       <= 8'hFF;
      fs_q        <= 1'b0;
      state_q     <= ST_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      blank_cnt_q <= blank_cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      fs_q        <= fs_d;
      state_q     <= state_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;

endmodule
